// File: rtl/rf_pkg.sv
// Shared widths and the writeback entry layout for the register-file write buffer.
// The data and address widths are fixed here, so every user of wb_entry_t agrees on the packing.
package rf_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;

    // r0 is hardwired to zero: writes to it are dropped and reads of it return zero.
    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of writeback entries. The occupancy counter tells full from empty.
// Every slot, its valid bit and the head index are exposed for the forwarding search.
module wb_fifo
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  wb_entry_t             push_entry,
    output wb_entry_t [DEPTH-1:0] entries,
    output logic      [DEPTH-1:0] valid,
    output logic      [PTR_W-1:0] head,
    output logic      [CNT_W-1:0] count,
    output logic                  full,
    output logic                  empty,
    output wb_entry_t             head_entry
);

    wb_entry_t [DEPTH-1:0] mem_r;
    logic      [PTR_W-1:0] head_r;
    logic      [PTR_W-1:0] tail_r;
    logic      [CNT_W-1:0] count_r;
    logic      [PTR_W-1:0] off_s;
    logic                  push_take_s;
    logic                  pop_take_s;

    assign full        = (count_r == CNT_W'(DEPTH));
    assign empty       = (count_r == {CNT_W{1'b0}});
    assign push_take_s = push && !full;
    assign pop_take_s  = pop && !empty;
    assign entries     = mem_r;
    assign head        = head_r;
    assign count       = count_r;
    assign head_entry  = mem_r[head_r];

    // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_take_s) begin
                mem_r[tail_r] <= push_entry;
                tail_r        <= tail_r + 1'b1;
            end
            if (pop_take_s) begin
                head_r <= head_r + 1'b1;
            end
            case ({push_take_s, pop_take_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // A slot is live when its distance from the head, modulo DEPTH, is below the occupancy.
    always_comb begin
        valid = {DEPTH{1'b0}};
        off_s = {PTR_W{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            off_s    = PTR_W'(i) - head_r;
            valid[i] = (CNT_W'(off_s) < count_r);
        end
    end

endmodule

// File: rtl/regfile_wb_buffer.sv
// Buffers pipeline writebacks, drains one per cycle onto the regfile write port, and forwards
// not-yet-committed values to both read paths. Data/address widths come from rf_pkg.
module regfile_wb_buffer
    import rf_pkg::*;
#(
    parameter int  DEPTH  = 4,
    localparam int PEND_W = $clog2(DEPTH + 2)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              drain_en,
    output logic              we3,
    output logic [ADDR_W-1:0] wa3,
    output logic [DATA_W-1:0] wd3,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [PEND_W-1:0] pending
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t [DEPTH-1:0] entries_s;
    logic      [DEPTH-1:0] valid_s;
    logic      [PTR_W-1:0] head_s;
    logic      [CNT_W-1:0] count_s;
    logic                  full_s;
    logic                  empty_s;
    wb_entry_t             head_entry_s;
    wb_entry_t             push_entry_s;
    logic                  push_s;
    logic                  pop_s;

    // wb_ready depends only on registered occupancy, never on drain_en.
    assign wb_ready            = !full_s;
    // r0 writes complete the handshake but are never stored.
    assign push_s              = wb_valid && !full_s && (wb_addr != REG_ZERO);
    assign pop_s               = drain_en && !empty_s;
    assign push_entry_s.addr   = wb_addr;
    assign push_entry_s.data   = wb_data;
    assign pending             = PEND_W'(count_s) + PEND_W'(we3);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .pop        (pop_s),
        .push_entry (push_entry_s),
        .entries    (entries_s),
        .valid      (valid_s),
        .head       (head_s),
        .count      (count_s),
        .full       (full_s),
        .empty      (empty_s),
        .head_entry (head_entry_s)
    );

    // Output stage: one regfile write per cycle; address/data hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3 <= 1'b0;
            wa3 <= {ADDR_W{1'b0}};
            wd3 <= {DATA_W{1'b0}};
        end else if (pop_s) begin
            we3 <= 1'b1;
            wa3 <= head_entry_s.addr;
            wd3 <= head_entry_s.data;
        end else begin
            we3 <= 1'b0;
        end
    end

    // Priority: r0 -> newest queued match -> output stage -> raw regfile.
    // Walking oldest to newest lets the last hit (the newest) win.
    function automatic logic [DATA_W-1:0] fwd_value(
        input logic      [ADDR_W-1:0] raddr,
        input logic      [DATA_W-1:0] raw,
        input wb_entry_t [DEPTH-1:0]  ents,
        input logic      [DEPTH-1:0]  vld,
        input logic      [PTR_W-1:0]  hd,
        input logic                   ovld,
        input logic      [ADDR_W-1:0] oaddr,
        input logic      [DATA_W-1:0] odata
    );
        logic [DATA_W-1:0] res_s;
        logic [PTR_W-1:0]  idx_s;
        res_s = (ovld && (oaddr == raddr)) ? odata : raw;
        for (int k = 0; k < DEPTH; k++) begin
            idx_s = hd + PTR_W'(k);
            res_s = (vld[idx_s] && (ents[idx_s].addr == raddr)) ? ents[idx_s].data : res_s;
        end
        return (raddr == REG_ZERO) ? {DATA_W{1'b0}} : res_s;
    endfunction

    // Read port 1 forwarding mux.
    always_comb begin
        rd1 = fwd_value(ra1, rf_rd1, entries_s, valid_s, head_s, we3, wa3, wd3);
    end

    // Read port 2 forwarding mux.
    always_comb begin
        rd2 = fwd_value(ra2, rf_rd2, entries_s, valid_s, head_s, we3, wa3, wd3);
    end

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// Self-checking bench: directed steps then random traffic against a queue-based reference model
// that also plays the role of the register file feeding rf_rd1/rf_rd2.
module tb_regfile_wb_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        drain_en;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rf_rd1;
    logic [31:0] rf_rd2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [2:0]  pending;

    // Reference model state.
    logic [31:0] mrf [32];
    ent_t        q[$];
    bit          o_v;
    logic [4:0]  o_a;
    logic [31:0] o_d;
    int          compared = 0;
    int          mism = 0;

    always #5 clk = ~clk;

    assign rf_rd1 = mrf[ra1];
    assign rf_rd2 = mrf[ra2];

    regfile_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wb_valid (wb_valid),
        .wb_ready (wb_ready),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .drain_en (drain_en),
        .we3      (we3),
        .wa3      (wa3),
        .wd3      (wd3),
        .ra1      (ra1),
        .ra2      (ra2),
        .rf_rd1   (rf_rd1),
        .rf_rd2   (rf_rd2),
        .rd1      (rd1),
        .rd2      (rd2),
        .pending  (pending)
    );

    function automatic logic [31:0] exp_rd(logic [4:0] ra);
        if (ra == 5'd0) return 32'h0;
        for (int k = q.size() - 1; k >= 0; k--)
            if (q[k].a == ra) return q[k].d;
        if (o_v && o_a == ra) return o_d;
        return mrf[ra];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        chk({tag, ".we3"}, 32'(we3), 32'(o_v));
        chk({tag, ".wa3"}, 32'(wa3), 32'(o_a));
        chk({tag, ".wd3"}, wd3, o_d);
        chk({tag, ".ready"}, 32'(wb_ready), (q.size() < DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".pending"}, 32'(pending), 32'(q.size() + int'(o_v)));
        chk({tag, ".rd1"}, rd1, exp_rd(ra1));
        chk({tag, ".rd2"}, rd2, exp_rd(ra2));
    endtask

    // One clock edge: model update mirrors the behavioural rules, then all outputs are checked.
    task automatic step(string tag);
        bit   acc;
        bit   pop;
        ent_t e;
        ent_t h;
        acc = !rst && wb_valid && (q.size() < DEPTH);
        pop = !rst && drain_en && (q.size() > 0);
        e.a = wb_addr;
        e.d = wb_data;
        @(posedge clk);
        if (o_v) mrf[o_a] = o_d;
        if (rst) begin
            q.delete();
            o_v = 1'b0;
            o_a = 5'd0;
            o_d = 32'd0;
        end else begin
            if (pop) begin
                h   = q.pop_front();
                o_v = 1'b1;
                o_a = h.a;
                o_d = h.d;
            end else begin
                o_v = 1'b0;
            end
            if (acc && e.a != 5'd0) q.push_back(e);
        end
        #1;
        check_all(tag);
    endtask

    task automatic push_one(logic [4:0] a, logic [31:0] d, string tag);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
        step(tag);
        wb_valid = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        mrf[0] = 32'hDEAD;
        o_v = 1'b0; o_a = 5'd0; o_d = 32'd0;
        rst = 1'b1; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        drain_en = 1'b0; ra1 = 5'd0; ra2 = 5'd0;

        step("rst_a");
        step("rst_b");
        chk("reset_we3", 32'(we3), 32'd0);
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_ready", 32'(wb_ready), 32'd1);
        rst = 1'b0;

        // Latency: accept at E, we3 in the cycle after E+1 only.
        drain_en = 1'b1;
        push_one(5'd8, 32'h6, "t1_e1");
        chk("t1_pend_e1", 32'(pending), 32'd1);
        chk("t1_we3_e1", 32'(we3), 32'd0);
        step("t1_e2");
        chk("t1_we3_e2", 32'(we3), 32'd1);
        chk("t1_wa3_e2", 32'(wa3), 32'd8);
        chk("t1_wd3_e2", wd3, 32'h6);
        chk("t1_pend_e2", 32'(pending), 32'd1);
        step("t1_e3");
        chk("t1_we3_e3", 32'(we3), 32'd0);
        chk("t1_pend_e3", 32'(pending), 32'd0);

        // Forwarding from queue, then output stage, then raw regfile.
        drain_en = 1'b0;
        ra1 = 5'd10;
        push_one(5'd10, 32'h6, "t2_push");
        chk("t2_rd1_queued", rd1, 32'h6);
        drain_en = 1'b1;
        step("t2_ostage");
        chk("t2_rd1_ostage", rd1, 32'h6);
        step("t2_commit");
        mrf[10] = 32'h55;
        #1;
        chk("t2_rd1_follows_rf", rd1, 32'h55);

        // Newest-wins forwarding and FIFO order.
        drain_en = 1'b0;
        ra2 = 5'd9;
        push_one(5'd9, 32'h3, "t3_p1");
        push_one(5'd9, 32'h7, "t3_p2");
        chk("t3_rd2_newest", rd2, 32'h7);
        drain_en = 1'b1;
        step("t3_d1");
        chk("t3_wd3_first", wd3, 32'h3);
        step("t3_d2");
        chk("t3_wd3_second", wd3, 32'h7);
        step("t3_d3");

        // Full: no push even while popping.
        drain_en = 1'b0;
        for (int i = 1; i <= 4; i++) push_one(5'(i), 32'h100 + 32'(i), "t4_fill");
        chk("t4_ready_full", 32'(wb_ready), 32'd0);
        chk("t4_pend_full", 32'(pending), 32'd4);
        wb_valid = 1'b1; wb_addr = 5'd5; wb_data = 32'h105;
        step("t4_held");
        chk("t4_pend_held", 32'(pending), 32'd4);
        drain_en = 1'b1;
        step("t4_pop_full");
        chk("t4_ready_after", 32'(wb_ready), 32'd1);
        chk("t4_wa3_1", 32'(wa3), 32'd1);
        drain_en = 1'b0;
        step("t4_accept5");
        wb_valid = 1'b0;
        drain_en = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            step("t4_drain");
            chk("t4_order", 32'(wa3), 32'(i));
        end
        step("t4_empty");

        // r0 writes are swallowed; r0 reads are zero.
        push_one(5'd0, 32'hFFFF, "t5_push");
        chk("t5_pend", 32'(pending), 32'd0);
        step("t5_idle");
        chk("t5_we3", 32'(we3), 32'd0);
        ra1 = 5'd0;
        #1;
        chk("t5_rd1_zero", rd1, 32'h0);

        // Reset discards pending writes.
        drain_en = 1'b0;
        for (int i = 11; i <= 14; i++) push_one(5'(i), 32'hA00 + 32'(i), "t6_fill");
        drain_en = 1'b1;
        step("t6_ostage");
        chk("t6_we3_pre", 32'(we3), 32'd1);
        chk("t6_pend_pre", 32'(pending), 32'd4);
        ra1 = 5'd13;
        rst = 1'b1;
        step("t6_rst");
        rst = 1'b0;
        chk("t6_we3", 32'(we3), 32'd0);
        chk("t6_pend", 32'(pending), 32'd0);
        chk("t6_ready", 32'(wb_ready), 32'd1);
        chk("t6_rd1_raw", rd1, mrf[13]);
        step("t6_after");

        // Random traffic on a small address range to create many forwarding hits.
        for (int n = 0; n < 500; n++) begin
            rst      = ($urandom_range(0, 63) == 0);
            wb_valid = $urandom_range(0, 1) == 1;
            wb_addr  = 5'($urandom_range(0, 7));
            wb_data  = $urandom;
            drain_en = $urandom_range(0, 3) != 0;
            ra1      = 5'($urandom_range(0, 7));
            ra2      = 5'($urandom_range(0, 7));
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
